fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one fifo_sync write port between N_REQ producers.
Each producer uses a valid/ready handshake. The arbiter grants one owner at a time and drives the FIFO's write and data_in.
It respects the FIFO full flag and caps each grant at BURST_MAX words for fairness.
It sits directly in front of fifo_sync, in the same clock domain.

Parameters:
DATA_WIDTH, 4, word width; matches the fifo_sync data_in width.
N_REQ, 4, number of requesters (2..8).
BURST_MAX, 4, maximum words transferred per grant before the arbiter rotates (>=1).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
req_valid  input  N_REQ  per-requester "word available".
req_data  input  N_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
req_ready  output  N_REQ  per-requester accept; a transfer occurs when req_valid[i] && req_ready[i] at a rising clk edge.
fifo_full  input  1  full flag from fifo_sync.
fifo_write  output  1  to fifo_sync write.
fifo_data_in  output  DATA_WIDTH  to fifo_sync data_in.
grant_active  output  1  high while in GRANT.
grant_id  output  3  current or last owner index.

Behaviour:
- Reset (reset=0, async): state=IDLE, last_owner=N_REQ-1, burst_cnt=0, grant_id=0, grant_active=0, req_ready=0, fifo_write=0, fifo_data_in=0.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any req_valid is high, pick the first requester with valid high, searching cyclically from last_owner+1.
  - Register it as owner and grant_id; clear burst_cnt; go to GRANT next cycle.
  - Arbitration latency is 1 cycle. No req_ready is asserted in IDLE.
- GRANT, combinational outputs:
  - req_ready[owner] = !fifo_full; all other req_ready bits = 0.
  - fifo_write = req_valid[owner] && !fifo_full.
  - fifo_data_in = req_data[owner slice] when fifo_write=1, else 0.
  - Zero-latency pass-through, so the FIFO never sees a write while full.
- GRANT, at each edge with fifo_write=1: burst_cnt increments.
- GRANT, release to IDLE and set last_owner=owner when either:
  - a write occurs with burst_cnt == BURST_MAX-1 (the burst limit is hit on that word), or
  - req_valid[owner] == 0 in a GRANT cycle (owner idle; no transfer that cycle).
- After release there is exactly one IDLE bubble cycle before the next grant.
- fifo_full while in GRANT: stall. The grant is held, burst_cnt is unchanged, and no release occurs unless req_valid[owner] drops.
- The owner may present a new word every cycle. Changes to req_valid or req_data on non-owners have no effect.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,... and each grant carries BURST_MAX words.
- A requester may not be granted twice in a row while another requester is valid.
- Reset asserted mid-burst: everything returns to reset values immediately. No partial write occurs after reset is asserted. The word in flight is lost; the producer retains it because its handshake did not complete.
- grant_id is undefined-free: it always holds a value in 0..N_REQ-1 and retains the last owner in IDLE.
- An N_REQ that does not fit the 3-bit grant_id is unsupported.

Test Plan:
1. Reset then single requester: req_valid=4'b0001 with data 1,2,3 on consecutive handshakes.
   -> grant_active rises 1 cycle after valid; FIFO receives 1,2,3 in order; grant_id=0.
   -> When valid drops: release, then IDLE.
2. All four requesters continuously valid, requester i sending words i*4+k, fifo_full=0.
   -> FIFO sequence: 0,1,2,3 (id0), 4,5,6,7 (id1), 8..11 (id2), 12..15 (id3).
   -> One IDLE bubble between bursts; id0 is granted again next.
3. Requester 2 granted; after 2 words, force fifo_full=1 for 3 cycles.
   -> req_ready=0 and fifo_write=0 for exactly 3 cycles; burst_cnt holds at 2.
   -> After full clears, 2 more words are written, then release.
4. Round-robin pointer: last_owner=1, req_valid=4'b0011 in IDLE.
   -> Requester 0 is granted, not 1.
   -> Then with only requester 1 valid: requester 1 is granted next.
5. reset pulled low mid-burst (after the 2nd word of requester 3).
   -> All outputs go to 0 asynchronously; the FIFO sees no write.
   -> After release, requester 0 has priority.
6. Owner drops req_valid for 1 cycle mid-burst while others are valid.
   -> The grant is released that cycle; the next grant goes to the next valid requester in cyclic order, not back to the former owner.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one fifo_sync write port between N_REQ
// valid/ready producers, with bursts capped at BURST_MAX words per grant.

module fifo_wr_arbiter_lane #(
  parameter int DW = 4
) (
  input  logic          i_sel,
  input  logic          i_valid,
  input  logic          i_full,
  input  logic [DW-1:0] i_data,
  output logic          o_ready,
  output logic          o_write,
  output logic [DW-1:0] o_data
);
  assign o_ready = i_sel & ~i_full;
  assign o_write = o_ready & i_valid;
  assign o_data  = o_write ? i_data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int N_REQ      = 4,
  parameter int BURST_MAX  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_write,
  output logic [DATA_WIDTH-1:0]       fifo_data_in,
  output logic                        grant_active,
  output logic [2:0]                  grant_id
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_MAX - 1);
  localparam logic [IW-1:0] LAST_REQ  = IW'(N_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                                r_state;
  state_t                                w_state_nxt;
  logic [IW-1:0]                         r_owner;
  logic [IW-1:0]                         r_last_owner;
  logic [CW-1:0]                         r_burst_cnt;

  logic [N_REQ-1:0]                      w_sel;
  logic [N_REQ-1:0]                      w_lane_rdy;
  logic [N_REQ-1:0]                      w_lane_wr;
  logic [N_REQ-1:0][DATA_WIDTH-1:0]      w_lane_data;
  logic                                  w_own_valid;
  logic                                  w_write;
  logic                                  w_release;
  logic [IW-1:0]                         w_pick_idx;
  logic [DATA_WIDTH-1:0]                 w_data_or;

  // One lane per requester; only the selected lane can pass a word through.
  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign w_sel[g] = (r_state == GRANT) && (r_owner == IW'(g));
    fifo_wr_arbiter_lane #(.DW(DATA_WIDTH)) u_lane (
      .i_sel   (w_sel[g]),
      .i_valid (req_valid[g]),
      .i_full  (fifo_full),
      .i_data  (req_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_ready (w_lane_rdy[g]),
      .o_write (w_lane_wr[g]),
      .o_data  (w_lane_data[g])
    );
  end

  assign w_own_valid = |(req_valid & w_sel);
  assign w_write     = |w_lane_wr;
  assign w_release   = (r_state == GRANT) &&
                       (!w_own_valid || (w_write && (r_burst_cnt == LAST_BEAT)));

  // Cyclic search starting at last_owner+1: smallest forward distance wins.
  always_comb begin
    int best;
    int d;
    best       = N_REQ;
    d          = 0;
    w_pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      d = i - int'(r_last_owner) - 1;
      if (d < 0) d = d + N_REQ;
      if (req_valid[i] && (d < best)) begin
        best       = d;
        w_pick_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|req_valid) w_state_nxt = GRANT;
      GRANT:   if (w_release)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_data_or = '0;
    for (int i = 0; i < N_REQ; i++) w_data_or = w_data_or | w_lane_data[i];
    req_ready    = w_lane_rdy;
    fifo_write   = w_write;
    fifo_data_in = w_data_or;
    grant_active = (r_state == GRANT);
    grant_id     = 3'(r_owner);
  end

  // A stalled cycle (full) has no write, so the count simply holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner      <= '0;
      r_last_owner <= LAST_REQ;
      r_burst_cnt  <= '0;
    end else if (r_state == IDLE) begin
      if (|req_valid) begin
        r_owner     <= w_pick_idx;
        r_burst_cnt <= '0;
      end
    end else if (w_release) begin
      r_last_owner <= r_owner;
    end else if (w_write) begin
      r_burst_cnt <= r_burst_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer/FIFO-log model plus hand-computed expectations.

module tb_fifo_wr_arbiter;
  localparam int DW = 4;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_write;
  logic [DW-1:0]   fifo_data_in;
  logic            grant_active;
  logic [2:0]      grant_id;

  int n_chk  = 0;
  int n_fail = 0;
  int base [N];
  int cnt  [N];
  int lim  [N];
  int wlog [$];
  int s_ga, s_id, s_wr, s_rdy, s_d;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .N_REQ(N), .BURST_MAX(4)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_write   (fifo_write),
    .fifo_data_in (fifo_data_in),
    .grant_active (grant_active),
    .grant_id     (grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int logv(input int k);
    return (k < wlog.size()) ? wlog[k] : -1;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(base[i] + cnt[i]);
  endtask

  task automatic set_req(input int i, input int b, input int l);
    base[i] = b; cnt[i] = 0; lim[i] = l; req_valid[i] = 1'b1;
    drive_data();
  endtask

  // Sample mid-cycle, then let the producers advance on completed handshakes.
  task automatic tick();
    logic [N-1:0] hs;
    @(negedge clk);
    hs    = req_valid & req_ready;
    s_ga  = int'(grant_active);
    s_id  = int'(grant_id);
    s_wr  = int'(fifo_write);
    s_rdy = int'(req_ready);
    s_d   = int'(fifo_data_in);
    if (fifo_write) wlog.push_back(int'(fifo_data_in));
    @(posedge clk); #1;
    for (int i = 0; i < N; i++)
      if (hs[i]) begin
        cnt[i]++;
        if (cnt[i] == lim[i]) req_valid[i] = 1'b0;
      end
    drive_data();
  endtask

  task automatic do_reset();
    reset = 1'b0; req_valid = '0; fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin base[i] = 0; cnt[i] = 0; lim[i] = 1000; end
    drive_data();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    wlog.delete();
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    #2;
    chk("rst_ga", int'(grant_active), 0);
    chk("rst_id", int'(grant_id), 0);
    chk("rst_wr", int'(fifo_write), 0);
    chk("rst_rdy", int'(req_ready), 0);
    chk("rst_data", int'(fifo_data_in), 0);

    // 1: single requester, three words then valid drops
    do_reset();
    set_req(0, 1, 3);
    tick(); chk("t1_idle_ga", s_ga, 0);
    tick(); chk("t1_grant_ga", s_ga, 1); chk("t1_id", s_id, 0); chk("t1_wr", s_wr, 1);
    tick(); tick();
    tick(); chk("t1_rel_ga", s_ga, 1); chk("t1_rel_wr", s_wr, 0);
    tick(); chk("t1_idle2_ga", s_ga, 0); chk("t1_id_kept", s_id, 0);
    chk("t1_nwords", wlog.size(), 3);
    for (int k = 0; k < 3; k++) chk("t1_word", logv(k), k + 1);

    // 2: all four continuously valid, full rotation with bubbles
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, i*4, 1000);
    for (int t = 1; t <= 21; t++) begin
      tick();
      if (t % 5 == 1) chk("t2_bubble", s_ga, 0);
    end
    chk("t2_nwords", wlog.size(), 16);
    for (int k = 0; k < 16; k++) chk("t2_word", logv(k), k);
    tick(); chk("t2_wrap_id", s_id, 0); chk("t2_wrap_data", s_d, 4);

    // 3: stall on full for three cycles mid-burst
    do_reset();
    set_req(2, 5, 1000);
    tick(); tick(); tick();
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t3_stall_rdy", s_rdy, 0); chk("t3_stall_wr", s_wr, 0); chk("t3_stall_ga", s_ga, 1);
    end
    fifo_full = 1'b0;
    tick(); chk("t3_resume", s_d, 7); chk("t3_resume_rdy", s_rdy, 4);
    tick(); chk("t3_last", s_d, 8);
    tick(); chk("t3_released", s_ga, 0);
    chk("t3_nwords", wlog.size(), 4);
    for (int k = 0; k < 4; k++) chk("t3_word", logv(k), k + 5);

    // 4: round-robin pointer after owner 1
    do_reset();
    set_req(1, 3, 1);
    tick(); tick(); chk("t4_first_id", s_id, 1);
    tick();
    set_req(0, 9, 1); set_req(1, 10, 1);
    tick(); chk("t4_idle", s_ga, 0);
    tick(); chk("t4_pick0", s_id, 0); chk("t4_pick0_d", s_d, 9);
    tick(); tick();
    tick(); chk("t4_pick1", s_id, 1); chk("t4_pick1_d", s_d, 10);
    chk("t4_nwords", wlog.size(), 3);

    // 5: reset asserted mid-burst of requester 3
    do_reset();
    set_req(3, 2, 1000);
    tick(); tick(); tick();
    #2 reset = 1'b0;
    #1;
    chk("t5_ga", int'(grant_active), 0); chk("t5_wr", int'(fifo_write), 0);
    chk("t5_rdy", int'(req_ready), 0);   chk("t5_id", int'(grant_id), 0);
    chk("t5_data", int'(fifo_data_in), 0);
    tick(); chk("t5_nowrite", s_wr, 0);
    chk("t5_nwords", wlog.size(), 2);
    for (int i = 0; i < N; i++) set_req(i, 0, 1000);
    reset = 1'b1;
    tick(); chk("t5_idle", s_ga, 0);
    tick(); chk("t5_prio0", s_id, 0); chk("t5_prio0_ga", s_ga, 1);

    // 6: owner drops valid one cycle mid-burst
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 0, 1000);
    tick(); tick(); chk("t6_own0", s_id, 0);
    req_valid[0] = 1'b0;
    tick(); chk("t6_drop_wr", s_wr, 0); chk("t6_drop_ga", s_ga, 1);
    req_valid[0] = 1'b1;
    tick(); chk("t6_bubble", s_ga, 0);
    tick(); chk("t6_next", s_id, 1); chk("t6_next_ga", s_ga, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
